// File: rtl/spi_device_core.sv
// SPI device-side core: oversampled SCLK/CS/MOSI, programmable character length,
// RX/TX data, control and status behind a simple register port.
module spi_device_core #(
  parameter int MAX_CHAR    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic [3:0]  be_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic        error_o,
  output logic        intr_rx_o,
  output logic        intr_tx_o,
  input  logic        sclk_i,
  input  logic        cs_ni,
  input  logic        sd_i,
  output logic        sd_o,
  output logic        sd_oe_o
);
  localparam int IW = $clog2(MAX_CHAR);
  localparam logic [6:0] MAX_LEN = 7'(MAX_CHAR);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_SHIFT = 2'd2} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, cs_sync_reg, sd_sync_reg;
  logic                   sclk_d_reg, cs_d_reg;
  logic                   sclk_s, cs_s, sd_s, sclk_rise, sclk_fall, cs_fall;
  logic                   sample_edge, drive_edge, abort;
  state_e                 state_reg, state_next;
  logic                   load_go, shift_go, char_done;
  logic [5:0]             char_len_reg;
  logic                   rx_negedge_reg, tx_negedge_reg, lsb_reg, ie_reg, en_reg;
  logic [MAX_CHAR-1:0]    rx_data_reg, tx_data_reg, rx_shift_reg, tx_shift_reg;
  logic [MAX_CHAR-1:0]    rx_next, rx_char, tx_first, tx_adv;
  logic                   rx_full_reg, tx_valid_reg, overrun_reg;
  logic [6:0]             cnt_reg, len_eff;
  logic [IW-1:0]          top_idx;
  logic                   first_bit, adv_bit, busy;
  logic                   wr_en, read_rx, rx_full_eff;
  logic [2:0]             reg_idx;
  logic [31:0]            rdata_next;
  logic                   unused_bits;

  assign error_o     = 1'b0;
  assign unused_bits = ^{addr_i[7:5], addr_i[1:0], be_i[3:2]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sclk_sync_reg <= '1;
      cs_sync_reg   <= '1;
      sd_sync_reg   <= '0;
      sclk_d_reg    <= 1'b1;
      cs_d_reg      <= 1'b1;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        sclk_sync_reg[i] <= sclk_sync_reg[i-1];
        cs_sync_reg[i]   <= cs_sync_reg[i-1];
        sd_sync_reg[i]   <= sd_sync_reg[i-1];
      end
      sclk_sync_reg[0] <= sclk_i;
      cs_sync_reg[0]   <= cs_ni;
      sd_sync_reg[0]   <= sd_i;
      sclk_d_reg       <= sclk_s;
      cs_d_reg         <= cs_s;
    end
  end

  assign sclk_s      = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_s        = cs_sync_reg[SYNC_STAGES-1];
  assign sd_s        = sd_sync_reg[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_d_reg;
  assign sclk_fall   = ~sclk_s & sclk_d_reg;
  assign cs_fall     = ~cs_s & cs_d_reg;
  assign sample_edge = rx_negedge_reg ? sclk_fall : sclk_rise;
  assign drive_edge  = tx_negedge_reg ? sclk_fall : sclk_rise;
  assign abort       = cs_s | ~en_reg;
  assign busy        = (state_reg != ST_IDLE);

  always_comb begin
    if (char_len_reg == 6'd0 || {1'b0, char_len_reg} > MAX_LEN) len_eff = MAX_LEN;
    else                                                         len_eff = {1'b0, char_len_reg};
  end
  assign top_idx = IW'(len_eff - 7'd1);

  // LSB-first characters arrive at the top of the shifter and are right-justified on completion
  assign rx_next   = lsb_reg ? {sd_s, rx_shift_reg[MAX_CHAR-1:1]} : {rx_shift_reg[MAX_CHAR-2:0], sd_s};
  assign rx_char   = lsb_reg ? (rx_next >> (MAX_LEN - len_eff)) : rx_next;
  assign tx_first  = tx_valid_reg ? tx_data_reg : '0;
  assign first_bit = lsb_reg ? tx_first[0] : tx_first[top_idx];
  assign tx_adv    = lsb_reg ? (tx_shift_reg >> 1) : (tx_shift_reg << 1);
  assign adv_bit   = lsb_reg ? tx_adv[0] : tx_adv[top_idx];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load_go    = 1'b0;
    shift_go   = 1'b0;
    char_done  = 1'b0;
    case (state_reg)
      ST_IDLE:  if (en_reg && cs_fall) state_next = ST_LOAD;
      ST_LOAD: begin
        load_go    = 1'b1;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_go = 1'b1;
        if (sample_edge && (cnt_reg + 7'd1 == len_eff)) begin
          char_done  = 1'b1;
          state_next = ST_LOAD;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
    if (abort) begin
      state_next = ST_IDLE;
      load_go    = 1'b0;
      shift_go   = 1'b0;
      char_done  = 1'b0;
    end
  end

  assign wr_en       = we_i & ~re_i;
  assign reg_idx     = addr_i[4:2];
  assign read_rx     = re_i && (reg_idx == 3'd0);
  assign rx_full_eff = rx_full_reg & ~read_rx;

  always_comb begin
    rdata_next = 32'd0;
    case (reg_idx)
      3'd0:    rdata_next = 32'(rx_data_reg);
      3'd2:    rdata_next = {19'd0, en_reg, ie_reg, lsb_reg, tx_negedge_reg, rx_negedge_reg,
                             2'd0, char_len_reg};
      3'd3:    rdata_next = {28'd0, busy, overrun_reg, tx_valid_reg, rx_full_reg};
      default: rdata_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_o <= '0;  intr_rx_o <= 1'b0;  intr_tx_o <= 1'b0;
      sd_o <= 1'b0;  sd_oe_o <= 1'b0;
      char_len_reg <= '0;  rx_negedge_reg <= 1'b0;  tx_negedge_reg <= 1'b0;
      lsb_reg <= 1'b0;  ie_reg <= 1'b0;  en_reg <= 1'b0;
      rx_data_reg <= '0;  tx_data_reg <= '0;  rx_shift_reg <= '0;  tx_shift_reg <= '0;
      rx_full_reg <= 1'b0;  tx_valid_reg <= 1'b0;  overrun_reg <= 1'b0;
      cnt_reg <= '0;
    end else begin
      intr_rx_o <= 1'b0;
      intr_tx_o <= 1'b0;
      sd_oe_o   <= busy;
      rdata_o   <= rdata_next;
      if (read_rx) rx_full_reg <= 1'b0;
      if (wr_en && reg_idx == 3'd3 && be_i[0] && wdata_i[2]) overrun_reg <= 1'b0;
      if (load_go) begin
        tx_shift_reg <= tx_first;
        sd_o         <= first_bit;
        cnt_reg      <= '0;
        rx_shift_reg <= '0;
        if (tx_valid_reg) begin
          tx_valid_reg <= 1'b0;
          intr_tx_o    <= ie_reg;
        end
      end
      if (shift_go) begin
        if (sample_edge) begin
          rx_shift_reg <= rx_next;
          cnt_reg      <= cnt_reg + 7'd1;
        end
        // A drive edge before the first sample would skip the preloaded bit
        if (drive_edge && cnt_reg != 7'd0) begin
          tx_shift_reg <= tx_adv;
          sd_o         <= adv_bit;
        end
        if (char_done) begin
          if (!rx_full_eff) begin
            rx_data_reg <= rx_char;
            rx_full_reg <= 1'b1;
            intr_rx_o   <= ie_reg;
          end else begin
            overrun_reg <= 1'b1;
          end
        end
      end
      if (wr_en && reg_idx == 3'd1) begin
        tx_data_reg  <= wdata_i[MAX_CHAR-1:0];
        tx_valid_reg <= 1'b1;
      end
      if (wr_en && reg_idx == 3'd2 && !busy) begin
        if (be_i[0]) char_len_reg <= wdata_i[5:0];
        if (be_i[1]) begin
          rx_negedge_reg <= wdata_i[8];
          tx_negedge_reg <= wdata_i[9];
          lsb_reg        <= wdata_i[10];
          ie_reg         <= wdata_i[11];
          en_reg         <= wdata_i[12];
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_device_core.sv
// Directed and randomized frames against a character-level reference model.
module tb_spi_device_core;
  localparam int HALF = 8;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic [7:0]  addr_i = '0;
  logic [31:0] wdata_i = '0, rdata_o;
  logic [3:0]  be_i = '0;
  logic        we_i = 1'b0, re_i = 1'b0, error_o, intr_rx_o, intr_tx_o;
  logic        sclk_i = 1'b0, cs_ni = 1'b1, sd_i = 1'b0, sd_o, sd_oe_o;

  spi_device_core #(.MAX_CHAR(32), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .be_i(be_i), .we_i(we_i), .re_i(re_i), .error_o(error_o), .intr_rx_o(intr_rx_o),
    .intr_tx_o(intr_tx_o), .sclk_i(sclk_i), .cs_ni(cs_ni), .sd_i(sd_i), .sd_o(sd_o),
    .sd_oe_o(sd_oe_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0, miscompares = 0;
  int rx_irq_seen = 0, tx_irq_seen = 0, exp_rx_irq = 0, exp_tx_irq = 0;

  always @(negedge clk_i) begin
    if (intr_rx_o) rx_irq_seen++;
    if (intr_tx_o) tx_irq_seen++;
  end

  // Reference model state: register contents as the software sees them
  logic [31:0] m_rxdata = '0, m_txdata = '0, m_ctrl = '0;
  bit m_rx_full = 0, m_overrun = 0, m_tx_valid = 0, m_ie = 0, m_lsb = 0, m_rxn = 0;
  int m_len = 32;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask(input int n);
    logic [31:0] one = 32'd1;
    return (n >= 32) ? 32'hFFFF_FFFF : ((one << n) - 32'd1);
  endfunction

  task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk_i);
    addr_i = 8'(idx * 4); wdata_i = d; be_i = be; we_i = 1'b1;
    @(negedge clk_i);
    we_i = 1'b0; be_i = '0;
  endtask

  task automatic rd(input int idx, output logic [31:0] d);
    @(negedge clk_i);
    addr_i = 8'(idx * 4); re_i = 1'b1;
    @(negedge clk_i);
    re_i = 1'b0;
    d = rdata_o;
  endtask

  task automatic set_ctrl(input int len, input bit rxn, input bit txn, input bit lsb,
                          input bit ie, input bit en);
    m_ctrl = {19'd0, en, ie, lsb, txn, rxn, 2'd0, 6'(len)};
    wr(2, m_ctrl, 4'hF);
    m_len = (len == 0) ? 32 : len;
    m_rxn = rxn; m_lsb = lsb; m_ie = ie;
  endtask

  task automatic tx_write(input logic [31:0] v);
    wr(1, v, 4'hF);
    m_txdata = v; m_tx_valid = 1;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    rd(3, d);
    chk(tag, d, {28'd0, 1'b0, m_overrun, m_tx_valid, m_rx_full});
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] d;
    rd(0, d);
    chk(tag, d, m_rxdata);
    m_rx_full = 0;
  endtask

  task automatic model_load(output logic [31:0] exp_miso);
    if (m_tx_valid) begin
      exp_miso = m_txdata & mask(m_len);
      m_tx_valid = 0;
      if (m_ie) exp_tx_irq++;
    end else exp_miso = '0;
  endtask

  task automatic model_done(input logic [31:0] ch);
    if (!m_rx_full) begin
      m_rxdata = ch & mask(m_len); m_rx_full = 1;
      if (m_ie) exp_rx_irq++;
    end else m_overrun = 1;
  endtask

  task automatic frame_begin();
    @(negedge clk_i); cs_ni = 1'b0;
    repeat (8) @(negedge clk_i);
  endtask

  task automatic frame_end();
    repeat (8) @(negedge clk_i); cs_ni = 1'b1;
    repeat (8) @(negedge clk_i);
  endtask

  // Master side: clocks nclk of the n bits of one character
  task automatic xfer(input logic [31:0] mosi, input int n, input int nclk, output logic [31:0] miso);
    int b;
    miso = '0;
    for (int i = 0; i < nclk; i++) begin
      b = m_lsb ? i : n - 1 - i;
      if (!m_rxn) begin
        sd_i = mosi[b];
        repeat (HALF) @(negedge clk_i);
        miso[b] = sd_o; sclk_i = 1'b1;
        repeat (HALF) @(negedge clk_i);
        sclk_i = 1'b0;
      end else begin
        sclk_i = 1'b1; sd_i = mosi[b];
        repeat (HALF) @(negedge clk_i);
        miso[b] = sd_o; sclk_i = 1'b0;
        repeat (HALF) @(negedge clk_i);
      end
    end
    if (!m_rxn) repeat (HALF) @(negedge clk_i);
  endtask

  task automatic one_char_frame(input logic [31:0] mosi, input string tag);
    logic [31:0] em, miso;
    frame_begin();
    model_load(em);
    xfer(mosi, m_len, m_len, miso);
    model_done(mosi);
    frame_end();
    chk({tag, "_miso"}, miso, em);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] d, em, em2, miso, mosi;
    int len;
    bit lsb, rxn;

    repeat (3) @(negedge clk_i);
    chk("rst_sd_o", {31'd0, sd_o}, 32'd0);
    chk("rst_sd_oe", {31'd0, sd_oe_o}, 32'd0);
    chk("rst_intr", {30'd0, intr_rx_o, intr_tx_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("error_o", {31'd0, error_o}, 32'd0);
    rst_ni = 1'b1;
    rd(2, d); chk("rst_ctrl", d, 32'd0);
    check_status("rst_status");
    rd(0, d); chk("rst_rxdata", d, 32'd0);

    // Mode 0, MSB first, 8 bits
    set_ctrl(8, 0, 1, 0, 1, 1);
    tx_write(32'hA5);
    check_status("t1_txvalid");
    one_char_frame(32'h3C, "t1");
    check_status("t1_status");
    read_rx("t1_rxdata");
    chk("t1_rx_irq", rx_irq_seen, exp_rx_irq);
    chk("t1_tx_irq", tx_irq_seen, exp_tx_irq);

    // 32-bit LSB-first, sampling on falling edge, nothing queued
    set_ctrl(0, 1, 0, 1, 1, 1);
    one_char_frame(32'hDEADBEEF, "t2");
    read_rx("t2_rxdata");
    chk("t2_tx_irq", tx_irq_seen, exp_tx_irq);

    // Two characters without reading: overrun
    set_ctrl(8, 0, 1, 0, 1, 1);
    frame_begin();
    model_load(em);  xfer(32'h11, 8, 8, miso); model_done(32'h11);
    chk("t3_miso0", miso, em);
    model_load(em2); xfer(32'h22, 8, 8, miso); model_done(32'h22);
    chk("t3_miso1", miso, em2);
    frame_end();
    chk("t3_rx_irq", rx_irq_seen, exp_rx_irq);
    check_status("t3_overrun");
    wr(3, 32'h4, 4'h1); m_overrun = 0;
    check_status("t3_ovr_clr");
    read_rx("t3_rxdata");

    // Abort after 5 of 8 bits
    tx_write(32'h5A);
    frame_begin();
    model_load(em);
    xfer(32'hFF, 8, 5, miso);
    @(negedge clk_i); cs_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    check_status("t4_abort");
    chk("t4_rx_irq", rx_irq_seen, exp_rx_irq);
    chk("t4_tx_irq", tx_irq_seen, exp_tx_irq);
    repeat (8) @(negedge clk_i);
    one_char_frame(32'hC3, "t4b");
    read_rx("t4b_rxdata");

    // CTRL write while busy is ignored
    frame_begin();
    model_load(em);
    wr(2, 32'h0000_1F03, 4'hF);
    rd(2, d); chk("t5_ctrl_busy", d, m_ctrl);
    xfer(32'h96, 8, 8, miso); model_done(32'h96);
    frame_end();
    chk("t5_miso", miso, em);
    read_rx("t5_rxdata");

    // ie=0: status updates, no pulses
    set_ctrl(8, 0, 1, 0, 0, 1);
    tx_write(32'h3C);
    one_char_frame(32'h81, "t6");
    check_status("t6_status");
    chk("t6_rx_irq", rx_irq_seen, exp_rx_irq);
    chk("t6_tx_irq", tx_irq_seen, exp_tx_irq);
    read_rx("t6_rxdata");

    // Randomized characters
    for (int k = 0; k < 6; k++) begin
      len = int'($urandom_range(0, 32));
      lsb = bit'($urandom_range(0, 1));
      rxn = bit'($urandom_range(0, 1));
      set_ctrl(len, rxn, ~rxn, lsb, 1, 1);
      if ($urandom_range(0, 1) == 1) tx_write($urandom);
      mosi = $urandom;
      one_char_frame(mosi, $sformatf("r%0d", k));
      check_status($sformatf("r%0d_status", k));
      read_rx($sformatf("r%0d_rxdata", k));
      chk($sformatf("r%0d_rx_irq", k), rx_irq_seen, exp_rx_irq);
      chk($sformatf("r%0d_tx_irq", k), tx_irq_seen, exp_tx_irq);
    end

    // Reset in the middle of a frame
    set_ctrl(8, 0, 1, 0, 1, 1);
    tx_write(32'hFF);
    frame_begin();
    xfer(32'h00, 8, 3, miso);
    addr_i = 8'h08;
    @(negedge clk_i); rst_ni = 1'b0;
    @(posedge clk_i); #1;
    chk("rst_mid_outs", {28'd0, sd_o, sd_oe_o, intr_rx_o, intr_tx_o}, 32'd0);
    chk("rst_mid_rdata", rdata_o, 32'd0);
    cs_ni = 1'b1; sclk_i = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    m_rx_full = 0; m_overrun = 0; m_tx_valid = 0; m_rxdata = '0;
    rd(2, d); chk("rst_mid_ctrl", d, 32'd0);
    check_status("rst_mid_status");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
